freq_display: RTL and testbench



---
 rtl/freq_display.sv | 141 ++++++++++++++
 tb/tb_freq_display.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/freq_display.sv
// freq_display: converts the frequency counter's 16-bit result to five BCD
// digits with a sequential shift-add-3 engine, then scans them onto a
// five-digit common-anode 7-segment display with optional leading-zero blanking.
module freq_display #(
  parameter int unsigned SCAN_DIV    = 10000,
  parameter bit          BLANK_ZEROS = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] bin_in,
  output logic [19:0] bcd,
  output logic        busy,
  output logic [6:0]  seg,
  output logic [4:0]  an
);

  localparam logic [15:0] SCAN_LAST = 16'(SCAN_DIV - 1);

  typedef enum logic {IDLE, CONV} state_t;

  state_t      state_q;
  logic [15:0] last_val_q;
  // Upper 20 bits are the BCD scratch, lower 16 bits the binary shift register.
  logic [35:0] work_q;
  logic [35:0] work_d;
  logic [4:0]  it_q;
  logic [19:0] bcd_q;
  logic        busy_q;

  logic [15:0] scan_cnt_q;
  logic [2:0]  idx_q;
  logic [6:0]  seg_q;
  logic [4:0]  an_q;

  logic [19:0] nib_adj;
  logic [3:0]  digit [5];
  logic [4:0]  blank;

  // Per-nibble correction of the scratch, plus per-digit value and blank flag.
  for (genvar gi = 0; gi < 5; gi++) begin : g_digit
    assign nib_adj[gi*4 +: 4] = (work_q[16 + gi*4 +: 4] >= 4'd5)
                              ? work_q[16 + gi*4 +: 4] + 4'd3
                              : work_q[16 + gi*4 +: 4];
    assign digit[gi] = bcd_q[gi*4 +: 4];
    if (gi == 0) begin : g_units
      // The units digit is always lit so a zero reading still shows "0".
      assign blank[gi] = 1'b0;
    end else begin : g_upper
      assign blank[gi] = BLANK_ZEROS && (bcd_q[19:gi*4] == '0);
    end
  end

  // Correct first, then shift the whole scratch:binary pair left by one.
  assign work_d = {nib_adj, work_q[15:0]} << 1;

  // 7-segment decode, active-low {g,f,e,d,c,b,a}; non-decimal nibbles go dark.
  function automatic logic [6:0] decode(input logic [3:0] nib);
    logic [6:0] s;
    case (nib)
      4'd0:    s = 7'h40;
      4'd1:    s = 7'h79;
      4'd2:    s = 7'h24;
      4'd3:    s = 7'h30;
      4'd4:    s = 7'h19;
      4'd5:    s = 7'h12;
      4'd6:    s = 7'h02;
      4'd7:    s = 7'h78;
      4'd8:    s = 7'h00;
      4'd9:    s = 7'h10;
      default: s = 7'h7F;
    endcase
    return s;
  endfunction

  // Converter FSM: start on a new input value, run 16 shift-add-3 steps, latch result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      last_val_q <= '0;
      work_q     <= '0;
      it_q       <= '0;
      bcd_q      <= '0;
      busy_q     <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (bin_in != last_val_q) begin
            work_q     <= {20'd0, bin_in};
            it_q       <= '0;
            last_val_q <= bin_in;
            busy_q     <= 1'b1;
            state_q    <= CONV;
          end
        end
        CONV: begin
          work_q <= work_d;
          it_q   <= it_q + 5'd1;
          if (it_q == 5'd15) begin
            bcd_q   <= work_d[35:16];
            busy_q  <= 1'b0;
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Digit scan timer: hold each digit SCAN_DIV cycles, then move to the next.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      scan_cnt_q <= '0;
      idx_q      <= '0;
    end else if (scan_cnt_q == SCAN_LAST) begin
      scan_cnt_q <= '0;
      idx_q      <= (idx_q == 3'd4) ? 3'd0 : idx_q + 3'd1;
    end else begin
      scan_cnt_q <= scan_cnt_q + 16'd1;
    end
  end

  // Registered display drive from the latched BCD only, so no partial result shows.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seg_q <= 7'h7F;
      an_q  <= 5'h1F;
    end else if (blank[idx_q]) begin
      seg_q <= 7'h7F;
      an_q  <= 5'h1F;
    end else begin
      seg_q <= decode(digit[idx_q]);
      an_q  <= ~(5'b00001 << idx_q);
    end
  end

  assign bcd  = bcd_q;
  assign busy = busy_q;
  assign seg  = seg_q;
  assign an   = an_q;

endmodule

// File: tb/tb_freq_display.sv
// tb_freq_display: drives two display back-ends (blanking on and off) with
// directed and random values and compares every cycle against a decimal model.
module tb_freq_display;

  localparam int SD = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic [15:0] bin_in = 16'd0;

  logic [19:0] bcd_b, bcd_n;
  logic        busy_b, busy_n;
  logic [6:0]  seg_b, seg_n;
  logic [4:0]  an_b, an_n;

  always #5 clk = ~clk;

  freq_display #(.SCAN_DIV(SD), .BLANK_ZEROS(1'b1)) dut_blank (
    .clk(clk), .rst_n(rst_n), .bin_in(bin_in),
    .bcd(bcd_b), .busy(busy_b), .seg(seg_b), .an(an_b)
  );

  freq_display #(.SCAN_DIV(SD), .BLANK_ZEROS(1'b0)) dut_full (
    .clk(clk), .rst_n(rst_n), .bin_in(bin_in),
    .bcd(bcd_n), .busy(busy_n), .seg(seg_n), .an(an_n)
  );

  int checks = 0;
  int failures = 0;

  // Reference model state: plain decimal values and a conversion countdown.
  int m_last, m_left, m_val, m_bcd, m_cyc;
  logic [6:0] e_seg_b, e_seg_n;
  logic [4:0] e_an_b, e_an_n;

  function automatic logic [6:0] seg_of(input int d);
    logic [6:0] s;
    case (d)
      0: s = 7'h40;  1: s = 7'h79;  2: s = 7'h24;  3: s = 7'h30;
      4: s = 7'h19;  5: s = 7'h12;  6: s = 7'h02;  7: s = 7'h78;
      8: s = 7'h00;  9: s = 7'h10;
      default: s = 7'h7F;
    endcase
    return s;
  endfunction

  function automatic int pow10(input int k);
    int p = 1;
    for (int i = 0; i < k; i++) p = p * 10;
    return p;
  endfunction

  function automatic logic [19:0] to_bcd(input int v);
    logic [19:0] r = '0;
    for (int k = 0; k < 5; k++) r[k*4 +: 4] = 4'((v / pow10(k)) % 10);
    return r;
  endfunction

  task automatic model_reset();
    m_last = 0; m_left = 0; m_val = 0; m_bcd = 0; m_cyc = 0;
    e_seg_b = 7'h7F; e_seg_n = 7'h7F; e_an_b = 5'h1F; e_an_n = 5'h1F;
  endtask

  task automatic model_edge();
    int idx, d;
    logic [4:0] one;
    if (!rst_n) begin
      model_reset();
      return;
    end
    one = 5'b00001;
    idx = (m_cyc / SD) % 5;
    d = (m_bcd / pow10(idx)) % 10;
    e_seg_n = seg_of(d);
    e_an_n = ~(one << idx);
    if (idx >= 1 && m_bcd < pow10(idx)) begin
      e_seg_b = 7'h7F; e_an_b = 5'h1F;
    end else begin
      e_seg_b = e_seg_n; e_an_b = e_an_n;
    end
    if (m_left == 0) begin
      if (int'(bin_in) != m_last) begin
        m_last = int'(bin_in);
        m_val = int'(bin_in);
        m_left = 16;
      end
    end else begin
      m_left--;
      if (m_left == 0) begin
        m_bcd = m_val;
        $display("TXN converted %0d -> bcd %05h", m_val, to_bcd(m_val));
      end
    end
    m_cyc++;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s t=%0t observed=%0h expected=%0h", tag, $time, obs, exp);
    end
  endtask

  task automatic check_all();
    chk("bcd_blank", 32'(bcd_b), 32'(to_bcd(m_bcd)));
    chk("bcd_full", 32'(bcd_n), 32'(to_bcd(m_bcd)));
    chk("busy_blank", 32'(busy_b), 32'(m_left != 0));
    chk("busy_full", 32'(busy_n), 32'(m_left != 0));
    chk("seg_blank", 32'(seg_b), 32'(e_seg_b));
    chk("an_blank", 32'(an_b), 32'(e_an_b));
    chk("seg_full", 32'(seg_n), 32'(e_seg_n));
    chk("an_full", 32'(an_n), 32'(e_an_n));
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    check_all();
  endtask

  task automatic run(input int n);
    repeat (n) step();
  endtask

  initial begin
    model_reset();
    // Asynchronous reset with bin_in = 0.
    #1 rst_n = 1'b0;
    #1 check_all();
    run(3);
    rst_n = 1'b1;
    run(24);

    // Full-scale value and a full scan frame of its digits.
    bin_in = 16'd65535;
    $display("TXN apply %0d", bin_in);
    run(45);

    // Interior zeros stay lit, top digit blanked.
    bin_in = 16'd1000;
    $display("TXN apply %0d", bin_in);
    run(45);

    // Change five cycles into a conversion: only the latest value follows.
    bin_in = 16'd1234;
    $display("TXN apply %0d", bin_in);
    run(6);
    bin_in = 16'd42;
    $display("TXN apply %0d (during conversion)", bin_in);
    run(50);

    // Reset pulse mid-conversion, checked before any clock edge.
    bin_in = 16'd500;
    $display("TXN apply %0d", bin_in);
    run(8);
    rst_n = 1'b0;
    model_reset();
    #1 check_all();
    run(2);
    bin_in = 16'd99;
    rst_n = 1'b1;
    $display("TXN apply %0d after reset", bin_in);
    run(40);

    // Back to zero: scan stepping on both variants.
    bin_in = 16'd0;
    $display("TXN apply %0d", bin_in);
    run(45);

    // Random values of mixed magnitude held for random durations.
    repeat (30) begin
      case ($urandom_range(0, 2))
        0: bin_in = 16'($urandom_range(0, 65535));
        1: bin_in = 16'($urandom_range(0, 99));
        default: bin_in = 16'($urandom_range(0, 9999));
      endcase
      $display("TXN apply %0d", bin_in);
      run(int'($urandom_range(1, 30)));
    end
    run(40);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
